// File: rtl/rr_mux_scheduler_if.sv
// rtl/rr_mux_scheduler_if.sv - requester bank / consumer bundle for the 8:1 round-robin scheduler
interface rr_mux_scheduler_if #(
    parameter int DATA_W = 1
);
    logic [7:0]          req;
    logic [8*DATA_W-1:0] din;
    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   dout;
    logic [2:0]          sel;
    logic [7:0]          grant;
    logic                busy;

    modport master (
        input  req, din, out_ready,
        output out_valid, dout, sel, grant, busy
    );

    modport slave (
        output req, din, out_ready,
        input  out_valid, dout, sel, grant, busy
    );
endinterface

// File: rtl/rr_mux_scheduler.sv
// rtl/rr_mux_scheduler.sv - 8:1 burst round-robin scheduler with internal mux; ARB_FIXED_PRIO_EN selects fixed lowest-index priority
module rr_mux_scheduler #(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst,
    rr_mux_scheduler_if.master bus
);
    typedef enum logic {IDLE, GNT} state_t;

    localparam logic [3:0] BURST_LEN = 4'(MAX_BURST);

    state_t      state, state_nxt;
    logic [2:0]  sel, sel_nxt;
    logic [7:0]  grant, grant_nxt;
    logic [3:0]  beat_cnt, beat_cnt_nxt;
    logic [2:0]  pick;
    logic        pick_vld;
    logic        out_valid;
    logic        xfer;
    logic [DATA_W-1:0] lanes [8];

`ifndef ARB_FIXED_PRIO_EN
    logic [2:0]  ptr, ptr_nxt;
    logic [2:0]  idx;
`endif

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lanes[i] = bus.din[i*DATA_W +: DATA_W];
    end

    // First requester at or after the rotation pointer wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[k]) begin
                pick     = 3'(k);
                pick_vld = 1'b1;
            end
        end
`else
        idx = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!pick_vld && bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
`endif
    end

    assign out_valid = (state == GNT) && bus.req[sel];
    assign xfer      = out_valid && bus.out_ready;

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
`ifndef ARB_FIXED_PRIO_EN
        ptr_nxt      = ptr;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    sel_nxt      = pick;
                    grant_nxt    = 8'b1 << pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = GNT;
                end
            end
            GNT: begin
                if (!bus.req[sel] || (xfer && (beat_cnt + 4'd1 == BURST_LEN))) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
`ifndef ARB_FIXED_PRIO_EN
                    ptr_nxt   = sel + 3'd1;
`endif
                end
                if (xfer) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
`ifndef ARB_FIXED_PRIO_EN
            ptr      <= ptr_nxt;
`endif
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.dout      = out_valid ? lanes[sel] : '0;
    assign bus.sel       = sel;
    assign bus.grant     = grant;
    assign bus.busy      = (state == GNT);
endmodule
